// File: rtl/param_stack_queue_if.sv
// ============================================================================
// Module      : param_stack_queue_if
// Description : Handshake/status bundle for param_stack_queue. Optional
//               peek ports appear when PSQ_PEEK_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface param_stack_queue_if #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
);
    localparam int CW = $clog2(DEPTH + 1);

    logic             push;
    logic             pop;
    logic             mode;
    logic [WIDTH-1:0] din;
    logic [WIDTH-1:0] dout;
    logic             dout_valid;
    logic [CW-1:0]    count;
    logic             full;
    logic             empty;
    logic             overflow;
    logic             underflow;
`ifdef PSQ_PEEK_EN
    logic [WIDTH-1:0] peek;
    logic [WIDTH-1:0] peek_deep;
`endif

    modport master (
        output push, pop, mode, din,
        input  dout, dout_valid, count, full, empty, overflow, underflow
`ifdef PSQ_PEEK_EN
        , input peek, peek_deep
`endif
    );

    modport slave (
        input  push, pop, mode, din,
        output dout, dout_valid, count, full, empty, overflow, underflow
`ifdef PSQ_PEEK_EN
        , output peek, peek_deep
`endif
    );
endinterface

`default_nettype wire

// File: rtl/param_stack_queue.sv
// ============================================================================
// Module      : param_stack_queue
// Description : DEPTH x WIDTH store with runtime LIFO/FIFO pop discipline.
//               Define PSQ_PEEK_EN to add combinational peek/peek_deep.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module param_stack_queue #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  wire logic          clk,
    input  wire logic          rstn,
    param_stack_queue_if.slave bus
);
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] c_depth = CW'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [CW-1:0]    r_count;
    logic [WIDTH-1:0] r_dout;
    logic             r_dout_valid;
    logic             r_overflow;
    logic             r_underflow;

    logic [WIDTH-1:0] w_mem_nxt [DEPTH];
    logic [CW-1:0]    w_count_nxt;
    logic [WIDTH-1:0] w_dout_nxt;
    logic             w_valid_nxt;
    logic             w_ovf_nxt;
    logic             w_unf_nxt;
    logic             w_empty;
    logic             w_full;
    logic [CW-1:0]    w_top;
    logic [WIDTH-1:0] w_newest;

    assign w_empty = (r_count == '0);
    assign w_full  = (r_count == c_depth);
    assign w_top   = r_count - CW'(1);

    always_comb begin
        w_newest = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (CW'(i) == w_top) begin
                w_newest = r_mem[i];
            end
        end
    end

    always_comb begin
        w_mem_nxt   = r_mem;
        w_count_nxt = r_count;
        w_dout_nxt  = r_dout;
        w_valid_nxt = 1'b0;
        w_ovf_nxt   = 1'b0;
        w_unf_nxt   = 1'b0;

        if (bus.push && bus.pop) begin
            w_valid_nxt = 1'b1;
            if (w_empty) begin
                w_dout_nxt = bus.din;
            end else begin
                w_dout_nxt = bus.mode ? r_mem[0] : w_newest;
                if (bus.mode) begin
                    for (int i = 0; i < DEPTH - 1; i++) begin
                        w_mem_nxt[i] = r_mem[i+1];
                    end
                    w_mem_nxt[DEPTH-1] = '0;
                end
                // Both disciplines end with din occupying the newest slot
                for (int i = 0; i < DEPTH; i++) begin
                    if (CW'(i) == w_top) begin
                        w_mem_nxt[i] = bus.din;
                    end
                end
            end
        end else if (bus.push) begin
            if (w_full) begin
                w_ovf_nxt = 1'b1;
            end else begin
                for (int i = 0; i < DEPTH; i++) begin
                    if (CW'(i) == r_count) begin
                        w_mem_nxt[i] = bus.din;
                    end
                end
                w_count_nxt = r_count + CW'(1);
            end
        end else if (bus.pop) begin
            if (w_empty) begin
                w_unf_nxt = 1'b1;
            end else begin
                w_valid_nxt = 1'b1;
                w_count_nxt = w_top;
                w_dout_nxt  = bus.mode ? r_mem[0] : w_newest;
                if (bus.mode) begin
                    for (int i = 0; i < DEPTH - 1; i++) begin
                        w_mem_nxt[i] = r_mem[i+1];
                    end
                    w_mem_nxt[DEPTH-1] = '0;
                end
                for (int i = 0; i < DEPTH; i++) begin
                    if (CW'(i) == w_top) begin
                        w_mem_nxt[i] = '0;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_count      <= '0;
            r_dout       <= '0;
            r_dout_valid <= 1'b0;
            r_overflow   <= 1'b0;
            r_underflow  <= 1'b0;
        end else begin
            r_mem        <= w_mem_nxt;
            r_count      <= w_count_nxt;
            r_dout       <= w_dout_nxt;
            r_dout_valid <= w_valid_nxt;
            r_overflow   <= w_ovf_nxt;
            r_underflow  <= w_unf_nxt;
        end
    end

    assign bus.dout       = r_dout;
    assign bus.dout_valid = r_dout_valid;
    assign bus.count      = r_count;
    assign bus.full       = w_full;
    assign bus.empty      = w_empty;
    assign bus.overflow   = r_overflow;
    assign bus.underflow  = r_underflow;

`ifdef PSQ_PEEK_EN
    logic [CW-1:0]    w_top2;
    logic [WIDTH-1:0] w_below_newest;

    assign w_top2 = r_count - CW'(2);

    always_comb begin
        w_below_newest = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (CW'(i) == w_top2) begin
                w_below_newest = r_mem[i];
            end
        end
    end

    assign bus.peek      = w_empty ? '0 : (bus.mode ? r_mem[0] : w_newest);
    assign bus.peek_deep = (r_count < CW'(2)) ? '0
                         : (bus.mode ? r_mem[1] : w_below_newest);
`endif

endmodule

`default_nettype wire

// File: doc/param_stack_queue.md
Name: param_stack_queue

Overview:
- Parametrised successor to the 4-entry, 1-bit push/pop shift store used for return-address and operand buffering in the MicroEV20 core.
- Holds DEPTH words of WIDTH bits.
- Runtime mode select chooses the pop discipline: LIFO (stack, newest out) or FIFO (queue, oldest out).
- Single clock domain; provides full/empty/count status and overflow/underflow error pulses to the sequencer.

Parameters:
- WIDTH, 8, data word width in bits (>=1)
- DEPTH, 4, number of storage entries (>=2)
- CW, $clog2(DEPTH+1), width of count output (derived localparam, not overridable)

Ports:
- clk  input  1  rising-edge clock
- rstn  input  1  asynchronous active-low reset
- push  input  1  write din this cycle
- pop  input  1  remove one entry this cycle
- mode  input  1  0 = LIFO, 1 = FIFO; sampled on every pop
- din  input  WIDTH  push data
- dout  output  WIDTH  registered pop data
- dout_valid  output  1  one-cycle pulse: dout updated by a pop
- count  output  CW  current number of stored entries
- full  output  1  count == DEPTH
- empty  output  1  count == 0
- overflow  output  1  one-cycle pulse: push rejected
- underflow  output  1  one-cycle pulse: pop rejected

Behaviour:
- Reset: one clock and one reset. rstn is asynchronous, active-low; assertion takes effect immediately, deassertion is synchronous to clk.
  - Values in reset: all entries = 0, count = 0, dout = 0, dout_valid = 0, overflow = 0, underflow = 0, empty = 1, full = 0.
  - Reset mid-operation discards all contents; there is no drain.
- Storage ordering: entries are kept ordered oldest (index 0) to newest (index count-1).
- Push only, not full: din is stored at index count; count += 1.
- Pop only, not empty, registered with latency 1 cycle (dout and dout_valid update on the edge where pop is sampled):
  - LIFO: dout <= entry[count-1].
  - FIFO: dout <= entry[0]; all entries shift down one index.
  - Both: count -= 1; vacated slot is cleared to 0; dout_valid = 1 for one cycle.
- Push + pop, not empty: count is unchanged; allowed even when full (no overflow).
  - LIFO: dout <= newest; din replaces the newest entry.
  - FIFO: dout <= oldest; shift down; din is written at index count-1.
- Push + pop, empty: bypass. dout <= din, dout_valid = 1, count stays 0, no underflow.
- Push only, full: din is dropped, contents unchanged, overflow = 1 for one cycle.
- Pop only, empty: dout holds its value, dout_valid = 0, underflow = 1 for one cycle.
- Mode switching: mode may change at any time. Contents are never reordered; mode selects only which end the next pop removes.
- Status outputs: full, empty and count are registered/derived from count and reflect state after the last edge.
- Error flags: overflow and underflow are not sticky.
- Width rules: count never exceeds DEPTH and never wraps. There is no arithmetic on data.

Optional Feature:
- Macro: PSQ_PEEK_EN
- Defined:
  - Adds output port peek [WIDTH-1:0]: combinational view of the entry the next pop would return (newest if mode = 0, oldest if mode = 1), or 0 when empty.
  - Adds output port peek_deep [WIDTH-1:0]: the entry adjacent to it (index count-2 in LIFO, index 1 in FIFO), or 0 if count < 2.
  - Used by the sequencer for zero-latency return-address prediction.
- Undefined: neither port exists; all other behaviour is identical.

Test Plan (WIDTH = 8, DEPTH = 4):
- Reset then idle: rstn low 3 cycles, release -> count = 0, empty = 1, full = 0, dout = 0x00, no pulses.
- LIFO order: push 0x11, 0x22, 0x33, 0x44 (full = 1 after 4th); mode = 0, pop x4 -> dout sequence 0x44, 0x33, 0x22, 0x11, each with dout_valid one cycle after the pop; empty = 1 at end.
- FIFO order with mode switch:
  - Push 0xA1, 0xA2, 0xA3; pop with mode = 1 -> 0xA1.
  - Pop with mode = 0 -> 0xA3.
  - Pop with mode = 1 -> 0xA2; count = 0.
- Boundary errors:
  - At full, push 0x55 -> overflow pulse, count = 4, later pops exclude 0x55.
  - At empty, pop -> underflow pulse, dout holds its previous value, dout_valid = 0.
- Simultaneous push + pop:
  - Full LIFO [0x11..0x44], push 0x99 + pop -> dout = 0x44, count = 4, next pop -> 0x99.
  - Empty, push 0x77 + pop -> dout = 0x77, dout_valid = 1, count = 0.
- Async reset mid-operation: with count = 3, assert rstn low between clock edges -> count = 0, empty = 1 immediately without waiting for clk; first pop after release -> underflow.
